// File: rtl/sam_ps2_pkg.sv
// rtl/sam_ps2_pkg.sv - shared PS/2 receive types and constants
package sam_ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = FRAME_BITS - 3;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // PS/2 uses odd parity over the data byte plus the parity bit
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-flop synchroniser, run-length deglitcher and fall pulse
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          meta;
    logic          synced;
    logic          level;
    logic [CW-1:0] run_cnt;

    // Two-flop synchroniser; idles high like an undriven PS/2 line
    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b1;
            synced <= 1'b1;
        end else begin
            meta   <= pin;
            synced <= meta;
        end
    end

    // Flip the filtered level only after FILTER_LEN consecutive opposite samples
    always_ff @(posedge clk) begin
        if (rst) begin
            level   <= 1'b1;
            run_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (synced == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CNT_LAST) begin
                level   <= synced;
                run_cnt <= '0;
                fall    <= level;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 device-to-host frame receiver with error pulses
module ps2_scan_receiver
    import sam_ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int STROBE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] scan,
    output logic       scan_received,
    output logic       parity_error,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STROBE_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] S_LOAD   = SW'(STROBE_CYCLES);
    localparam logic [SW-1:0] S_ONE    = SW'(1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    ps2_state_t    state;
    ps2_state_t    state_next;
    logic          clk_fall;
    logic          data_meta;
    logic          data_sync;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] strobe_cnt;
    logic          timeout;
    logic          good;
    logic          perr;
    logic          ferr;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .pin  (ps2clk),
        .fall (clk_fall)
    );

    // Data line only needs synchronising: it is sampled long after it settles
    always_ff @(posedge clk) begin
        if (rst) begin
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            data_meta <= ps2data;
            data_sync <= data_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: advance on each clock fall; a timeout aborts to IDLE
    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else if (clk_fall) begin
            case (state)
                IDLE:    if (!data_sync) state_next = DATA;
                DATA:    if (bit_cnt == BIT_LAST) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Frame verdicts; a fall in the terminal-count cycle suppresses the timeout
    always_comb begin
        timeout = 1'b0;
        good    = 1'b0;
        perr    = 1'b0;
        ferr    = 1'b0;
        if (state != IDLE && !clk_fall && tcnt == T_LAST) begin
            timeout = 1'b1;
        end
        if (state == STOP && clk_fall) begin
            if (!data_sync) begin
                ferr = 1'b1;
            end else if (odd_parity_ok(shift, par_bit)) begin
                good = 1'b1;
            end else begin
                perr = 1'b1;
            end
        end
    end

    // Bit collection and inactivity counter
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tcnt    <= '0;
        end else begin
            if (state == IDLE || clk_fall || timeout) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
            if (clk_fall) begin
                case (state)
                    IDLE: bit_cnt <= '0;
                    DATA: begin
                        shift   <= {data_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY:  par_bit <= data_sync;
                    default: ;
                endcase
            end
        end
    end

    // Registered outputs: byte latch, stretched strobe and one-cycle error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            scan          <= 8'h00;
            scan_received <= 1'b0;
            parity_error  <= 1'b0;
            frame_error   <= 1'b0;
            strobe_cnt    <= '0;
        end else begin
            parity_error <= perr;
            frame_error  <= ferr | timeout;
            if (good) begin
                scan          <= shift;
                scan_received <= 1'b1;
                strobe_cnt    <= S_LOAD;
            end else if (strobe_cnt != '0) begin
                strobe_cnt    <= strobe_cnt - 1'b1;
                scan_received <= (strobe_cnt != S_ONE);
            end else begin
                scan_received <= 1'b0;
            end
        end
    end

endmodule
